// File: rtl/spi_slave_cmd_ctrl.sv
// SPI-side command/register front end: assembles LSB-first frames on sclk falling edges and
// decodes command/data frame pairs into a register bank, with a toggle handshake per write.
module spi_slave_cmd_ctrl #(
  parameter int ADDR_W = 3
) (
  input  logic                        reset,
  input  logic                        sclk,
  input  logic                        cs,
  input  logic                        mosi,
  output logic [7:0]                  tx_byte,
  output logic [8*(2**ADDR_W)-1:0]    regs,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [7:0]                  wr_data,
  output logic                        wr_toggle,
  output logic                        err
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WR_DATA, RD_DATA} state_t;

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt;
  logic [6:0]        sh_q;
  logic [7:0]        rx_byte;
  logic              frame_done;
  logic              cmd_rsvd;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wr_cnt_q, wr_cnt_d;
  logic              err_d;
  logic [7:0]        tx_d;
  logic              do_wr;
  logic [7:0]        reg_q [NREG];

  // Chip select high abandons any partial frame so the next one starts at bit 0.
  always_ff @(negedge sclk or posedge reset or posedge cs) begin
    if (reset)   bit_cnt <= 3'd0;
    else if (cs) bit_cnt <= 3'd0;
    else         bit_cnt <= bit_cnt + 3'd1;
  end

  // sh_q holds the seven most recent bits; the live mosi bit completes the byte.
  assign rx_byte    = {mosi, sh_q};
  assign frame_done = ~cs & (bit_cnt == 3'd7);
  assign cmd_rsvd   = |rx_byte[6:ADDR_W];
  assign cmd_addr   = rx_byte[ADDR_W-1:0];

  always_ff @(negedge sclk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    err_d    = err;
    wr_cnt_d = wr_cnt_q;
    tx_d     = tx_byte;
    do_wr    = 1'b0;
    if (frame_done) begin
      case (state_q)
        IDLE: begin
          if (cmd_rsvd) begin
            err_d = 1'b1;
          end else begin
            addr_d  = cmd_addr;
            state_d = rx_byte[7] ? WR_DATA : RD_DATA;
          end
        end
        WR_DATA: begin
          do_wr    = 1'b1;
          wr_cnt_d = wr_cnt_q + 4'd1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
      // Status reflects this frame's effects so the slave reports them on the next frame.
      if (state_q == IDLE && !cmd_rsvd && !rx_byte[7]) tx_d = reg_q[cmd_addr];
      else                                             tx_d = {3'b101, err_d, wr_cnt_d};
    end
  end

  always_ff @(negedge sclk or posedge reset) begin
    if (reset) begin
      sh_q      <= '0;
      addr_q    <= '0;
      wr_cnt_q  <= 4'd0;
      err       <= 1'b0;
      tx_byte   <= 8'hA0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
      wr_toggle <= 1'b0;
      for (int k = 0; k < NREG; k++) reg_q[k] <= 8'h00;
    end else begin
      if (!cs) sh_q <= rx_byte[7:1];
      addr_q   <= addr_d;
      wr_cnt_q <= wr_cnt_d;
      err      <= err_d;
      tx_byte  <= tx_d;
      if (do_wr) begin
        reg_q[addr_q] <= rx_byte;
        wr_addr       <= addr_q;
        wr_data       <= rx_byte;
        wr_toggle     <= ~wr_toggle;
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs[8*g +: 8] = reg_q[g];
  end

endmodule

// File: tb/tb_spi_slave_cmd_ctrl.sv
// Bench for spi_slave_cmd_ctrl: directed protocol sequences plus random frames against a
// transaction-level model of the register bank and status byte.
module tb_spi_slave_cmd_ctrl;

  logic        reset, sclk, cs, mosi;
  logic [7:0]  tx_byte;
  logic [63:0] regs;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_toggle, err;

  spi_slave_cmd_ctrl #(.ADDR_W(3)) dut (
    .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi),
    .tx_byte(tx_byte), .regs(regs), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_toggle(wr_toggle), .err(err)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: what the next complete frame means (0 = command, 1 = write data, 2 = read dummy).
  logic [7:0] m_reg [8];
  int         m_mode;
  logic [2:0] m_addr, m_wa;
  logic [7:0] m_wd, m_tx;
  logic       m_err, m_tog;
  int         m_wcnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    return 8'hA0 + (m_err ? 8'h10 : 8'h00) + 8'(m_wcnt);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 8; k++) m_reg[k] = 8'h00;
    m_mode = 0; m_addr = 0; m_wa = 0; m_wd = 0;
    m_err = 0; m_tog = 0; m_wcnt = 0; m_tx = 8'hA0;
  endtask

  task automatic m_frame(input logic [7:0] b);
    if (m_mode == 1) begin
      m_reg[m_addr] = b; m_wa = m_addr; m_wd = b; m_tog = ~m_tog;
      m_wcnt = (m_wcnt + 1) % 16; m_tx = m_status(); m_mode = 0;
    end else if (m_mode == 2) begin
      m_tx = m_status(); m_mode = 0;
    end else if (b[6:3] != 4'd0) begin
      m_err = 1; m_tx = m_status();
    end else begin
      m_addr = b[2:0];
      if (b[7]) begin m_mode = 1; m_tx = m_status(); end
      else      begin m_mode = 2; m_tx = m_reg[b[2:0]]; end
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] e;
    for (int k = 0; k < 8; k++) e[8*k +: 8] = m_reg[k];
    chk({tag, ".tx"},   64'(tx_byte),   64'(m_tx));
    chk({tag, ".regs"}, regs,           e);
    chk({tag, ".wa"},   64'(wr_addr),   64'(m_wa));
    chk({tag, ".wd"},   64'(wr_data),   64'(m_wd));
    chk({tag, ".tog"},  64'(wr_toggle), 64'(m_tog));
    chk({tag, ".err"},  64'(err),       64'(m_err));
  endtask

  // Drives nbits of b LSB first; a full frame is checked before cs rises.
  task automatic frame(input logic [7:0] b, input int nbits = 8);
    cs = 1'b0; #4;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[i]; #2; sclk = 1'b1; #5; sclk = 1'b0; #3;
    end
    if (nbits == 8) begin
      m_frame(b);
      chk("frame.tx", 64'(tx_byte), 64'(m_tx));
    end
    cs = 1'b1; #6;
  endtask

  task automatic do_reset();
    reset = 1'b1; #3; m_reset(); reset = 1'b0; #3;
  endtask

  // Reset arrives while cs is low partway through a frame.
  task automatic frame_rst(input logic [7:0] b, input int nbits);
    cs = 1'b0; #4;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[i]; #2; sclk = 1'b1; #5; sclk = 1'b0; #3;
    end
    reset = 1'b1; #2;
    m_reset();
    check_all("midrst");
    reset = 1'b0; #2;
    cs = 1'b1; #6;
  endtask

  initial begin
    reset = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    m_reset();
    #5;
    do_reset();
    check_all("reset");
    chk("reset.tx_const", 64'(tx_byte), 64'h00A0);

    frame(8'h83); frame(8'h5C);
    check_all("wr3");
    chk("wr3.reg", 64'(regs[31:24]), 64'h5C);
    chk("wr3.tx",  64'(tx_byte),     64'hA1);

    frame(8'h03);
    chk("rd3.tx", 64'(tx_byte), 64'h5C);
    frame(8'hFF);
    chk("rd3.dummy_tx", 64'(tx_byte), 64'hA1);
    check_all("rd3");

    frame(8'h13);
    chk("rsvd.err", 64'(err),     64'h1);
    chk("rsvd.tx",  64'(tx_byte), 64'hB1);
    frame(8'h81); frame(8'h22);
    chk("rsvd.wr1", 64'(regs[15:8]), 64'h22);
    chk("rsvd.tx2", 64'(tx_byte),    64'hB2);
    check_all("rsvd");

    frame(8'h85); frame(8'h77, 5);
    check_all("short");
    frame(8'h77);
    chk("short.reg5", 64'(regs[47:40]), 64'h77);
    check_all("short2");

    do_reset();
    for (int i = 0; i < 16; i++) begin
      frame(8'h80); frame(8'(i));
    end
    chk("wrap.reg0", 64'(regs[7:0]), 64'h0F);
    chk("wrap.tx",   64'(tx_byte),   64'hA0);
    chk("wrap.tog",  64'(wr_toggle), 64'h0);
    check_all("wrap");

    frame(8'h82);
    frame_rst(8'h99, 4);
    chk("midrst.tx", 64'(tx_byte), 64'hA0);
    frame(8'h82); frame(8'h99);
    chk("midrst.reg2", 64'(regs[23:16]), 64'h99);
    check_all("after_rst");

    for (int n = 0; n < 300; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      b = 8'($urandom);
      if (r < 4) begin
        frame_rst(b, $urandom_range(1, 7));
      end else if (r < 14) begin
        frame(b, $urandom_range(1, 7));
      end else begin
        if (m_mode == 0 && $urandom_range(0, 9) < 8) b = {b[7], 4'b0000, b[2:0]};
        frame(b);
      end
      check_all("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
